// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch
// Turns each VGA draw coordinate into a sprite ROM address, waits out the
// ROM's one-clock read, then hands the colour index to the palette. The
// sprite_on flag tells the colour mapper that the pixel is inside the sprite
// and not transparent. A per-vsync divider steps the animation pose.
//
// Pipeline (one pixel per clock, no stalls):
//   stage 0 : box test on DrawX/DrawY against the latched sprite position
//   stage 1 : rom_addr_q, in_box_d1_q
//   stage 2 : ROM output register (external), in_box_d2_q
//   stage 3 : pal_index_q, sprite_on_q
//
// Position and pose change only on frame_start. A sprite that moves
// mid-frame therefore cannot tear, and every pixel of a frame shows one pose.

module sprite_pixel_fetch #(
    parameter int          SPR_W      = 64,
    parameter int          SPR_H      = 64,
    parameter int          NUM_FRAMES = 4,
    parameter int          FRAME_DIV  = 8,
    parameter logic [3:0]  TRANSP_IDX = 4'h0,
    parameter int          ADDR_W     = $clog2(NUM_FRAMES * SPR_W * SPR_H),
    localparam int         FR_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              anim_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pal_index,
    output logic              sprite_on,
    output logic [FR_W-1:0]   anim_frame
);

    localparam int                DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [FR_W-1:0]   FR_LAST  = FR_W'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

    // Latched sprite position and its validity.
    logic [9:0]        sx_l_q, sx_l_d;
    logic [9:0]        sy_l_q, sy_l_d;
    logic              pos_valid_q, pos_valid_d;

    // Animation divider and pose.
    logic [DIV_W-1:0]  div_q, div_d;
    logic [FR_W-1:0]   anim_frame_q, anim_frame_d;

    // Pipeline registers.
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              in_box_d1_q, in_box_d1_d;
    logic              in_box_d2_q, in_box_d2_d;
    logic [3:0]        pal_index_q, pal_index_d;
    logic              sprite_on_q, sprite_on_d;

    // Stage-0 intermediates.
    logic [10:0]       x_ext, y_ext;
    logic [10:0]       x_hi, y_hi;
    logic              in_box;
    logic [9:0]        dx_raw, dy_raw;
    logic [ADDR_W-1:0] frame_base;
    logic [ADDR_W-1:0] pix_off;

    // Position latch: sample SpriteX/SpriteY only at the start of vertical blank.
    always_comb begin
        sx_l_d      = sx_l_q;
        sy_l_d      = sy_l_q;
        pos_valid_d = pos_valid_q;
        if (frame_start) begin
            sx_l_d      = SpriteX;
            sy_l_d      = SpriteY;
            pos_valid_d = 1'b1;
        end
    end

    // Pose divider: count enabled frame_start pulses, step the pose on the last one.
    always_comb begin
        div_d        = div_q;
        anim_frame_d = anim_frame_q;
        if (frame_start && anim_en) begin
            if (div_q == DIV_LAST) begin
                div_d        = '0;
                anim_frame_d = (anim_frame_q == FR_LAST) ? '0 : anim_frame_q + FR_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Stage 0: box test in 11 bits so a sprite near column 1023 never wraps to 0.
    always_comb begin
        x_ext  = {1'b0, DrawX};
        y_ext  = {1'b0, DrawY};
        x_hi   = {1'b0, sx_l_q} + 11'(SPR_W);
        y_hi   = {1'b0, sy_l_q} + 11'(SPR_H);
        in_box = pos_valid_q
                 && (x_ext >= {1'b0, sx_l_q}) && (x_ext < x_hi)
                 && (y_ext >= {1'b0, sy_l_q}) && (y_ext < y_hi);
    end

    // Stage 0: address arithmetic; outside the box the frame base address is issued.
    always_comb begin
        dx_raw     = DrawX - sx_l_q;
        dy_raw     = DrawY - sy_l_q;
        frame_base = ADDR_W'(anim_frame_q) * FRAME_SZ;
        if (in_box) begin
            pix_off = ADDR_W'(dy_raw) * ADDR_W'(SPR_W) + ADDR_W'(dx_raw);
        end else begin
            pix_off = '0;
        end
    end

    // Stages 1..3 next-state: address register, flag delay line, palette output.
    always_comb begin
        rom_addr_d  = frame_base + pix_off;
        in_box_d1_d = in_box;
        in_box_d2_d = in_box_d1_q;
        pal_index_d = in_box_d2_q ? rom_data : TRANSP_IDX;
        sprite_on_d = in_box_d2_q && (rom_data != TRANSP_IDX);
    end

    // Control state: latched position and animation sequencing.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_l_q       <= '0;
            sy_l_q       <= '0;
            pos_valid_q  <= 1'b0;
            div_q        <= '0;
            anim_frame_q <= '0;
        end else begin
            sx_l_q       <= sx_l_d;
            sy_l_q       <= sy_l_d;
            pos_valid_q  <= pos_valid_d;
            div_q        <= div_d;
            anim_frame_q <= anim_frame_d;
        end
    end

    // Pixel pipeline; async reset forces the outputs to transparent at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            in_box_d1_q <= 1'b0;
            in_box_d2_q <= 1'b0;
            pal_index_q <= TRANSP_IDX;
            sprite_on_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            in_box_d1_q <= in_box_d1_d;
            in_box_d2_q <= in_box_d2_d;
            pal_index_q <= pal_index_d;
            sprite_on_q <= sprite_on_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pal_index  = pal_index_q;
    assign sprite_on  = sprite_on_q;
    assign anim_frame = anim_frame_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Bench for sprite_pixel_fetch: a synchronous ROM model feeds the DUT, and a
// coordinate-level reference model predicts rom_addr, pal_index, sprite_on and
// anim_frame for every pixel. Directed scenarios are followed by random traffic.

module tb_sprite_pixel_fetch;

    localparam int SPR_W      = 64;
    localparam int SPR_H      = 64;
    localparam int NUM_FRAMES = 4;
    localparam int FRAME_DIV  = 8;
    localparam int TRANSP     = 0;
    localparam int ROM_DEPTH  = NUM_FRAMES * SPR_W * SPR_H;

    logic        Clk;
    logic        Reset_n;
    logic        frame_start;
    logic        anim_en;
    logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
    logic [13:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  pal_index;
    logic        sprite_on;
    logic [1:0]  anim_frame;

    logic [3:0]  mem [0:ROM_DEPTH-1];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int m_sx, m_sy, m_valid, m_div, m_frame;
    int q_pal[$];
    int q_on[$];

    sprite_pixel_fetch dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_start(frame_start),
        .anim_en    (anim_en),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .SpriteX    (SpriteX),
        .SpriteY    (SpriteY),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pal_index  (pal_index),
        .sprite_on  (sprite_on),
        .anim_frame (anim_frame)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Synchronous ROM with one clock of read latency.
    always @(posedge Clk) rom_data <= mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_valid = 0; m_div = 0; m_frame = 0;
        q_pal.delete();
        q_on.delete();
        // Two pixels' worth of pipeline are empty (transparent) after reset.
        repeat (2) begin
            q_pal.push_back(TRANSP);
            q_on.push_back(0);
        end
    endtask

    // Present one pixel for one clock and check everything the model predicts.
    task automatic cycle(input bit fs, input int x, input int y);
        int in_b, addr, ep, eon, op, oon;
        frame_start = fs;
        DrawX = x[9:0];
        DrawY = y[9:0];
        in_b = (m_valid != 0) && x >= m_sx && x < m_sx + SPR_W && y >= m_sy && y < m_sy + SPR_H;
        addr = m_frame * SPR_W * SPR_H + (in_b ? (y - m_sy) * SPR_W + (x - m_sx) : 0);
        ep   = in_b ? int'(mem[addr]) : TRANSP;
        eon  = (in_b && int'(mem[addr]) != TRANSP) ? 1 : 0;
        q_pal.push_back(ep);
        q_on.push_back(eon);
        if (fs) begin
            m_sx = int'(SpriteX);
            m_sy = int'(SpriteY);
            m_valid = 1;
            if (anim_en) begin
                m_div++;
                if (m_div == FRAME_DIV) begin
                    m_div = 0;
                    m_frame = (m_frame + 1) % NUM_FRAMES;
                end
            end
        end
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        op  = q_pal.pop_front();
        oon = q_on.pop_front();
        chk("rom_addr", rom_addr, addr);
        chk("pal_index", pal_index, op);
        chk("sprite_on", sprite_on, oon);
        chk("anim_frame", anim_frame, m_frame);
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
            cycle(1'b0, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        end
    endtask

    initial begin
        int x, y;
        for (int i = 0; i < ROM_DEPTH; i++) mem[i] = 4'($urandom_range(1, 15));
        mem[131]  = 4'hD;   // pose 0, dy=2, dx=3
        mem[650]  = 4'h0;   // pose 0, dy=10, dx=10: transparent inside pixel
        mem[4096] = 4'h7;   // pose 1 origin
        mem[4756] = 4'h9;   // pose 1, dy=10, dx=20

        Reset_n = 1'b0;
        frame_start = 1'b0;
        anim_en = 1'b0;
        DrawX = '0; DrawY = '0; SpriteX = '0; SpriteY = '0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_pal_index", pal_index, TRANSP);
        chk("rst_sprite_on", sprite_on, 0);
        chk("rst_anim_frame", anim_frame, 0);
        Reset_n = 1'b1;
        model_reset();

        // 1: no frame_start yet, nothing may be drawn even over the origin box.
        for (int yy = 0; yy < 64; yy += 8)
            for (int xx = 0; xx < 64; xx++)
                cycle(1'b0, xx, yy);
        chk("t1_no_hit", sprite_on, 0);

        // 2: latch sprite at (100,50), fetch pixel (103,52).
        SpriteX = 10'd100; SpriteY = 10'd50;
        cycle(1'b1, 0, 0);
        cycle(1'b0, 103, 52);
        chk("t2_addr_131", rom_addr, 131);
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        chk("t2_pal_D", pal_index, 4'hD);
        chk("t2_on", sprite_on, 1);

        // 3: just outside left/right edges, and a transparent inside pixel.
        cycle(1'b0, 99, 52);
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        chk("t3_left_off", sprite_on, 0);
        cycle(1'b0, 164, 52);
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        chk("t3_right_off", sprite_on, 0);
        cycle(1'b0, 110, 60);
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        chk("t3_transp_off", sprite_on, 0);

        // 4: pose advance every 8 enabled pulses, wrap after 32.
        anim_en = 1'b1;
        pulse_frames(8);
        chk("t4_pose1", anim_frame, 1);
        pulse_frames(24);
        chk("t4_wrap0", anim_frame, 0);
        pulse_frames(8);
        cycle(1'b0, 100, 50);
        chk("t4_addr_4096", rom_addr, 4096);

        // 5: mid-frame move ignored; disabled pulses freeze the pose.
        anim_en = 1'b0;
        cycle(1'b1, 0, 0);
        SpriteX = 10'd300;
        cycle(1'b0, 100, 50);
        cycle(1'b0, 300, 50);
        cycle(1'b0, 0, 0);
        chk("t5_old_box_hit", sprite_on, 1);
        cycle(1'b0, 0, 0);
        chk("t5_new_box_miss", sprite_on, 0);
        pulse_frames(20);
        chk("t5_pose_frozen", anim_frame, 1);

        // 6: sprite clipped at the right edge, no wrap into low columns.
        SpriteX = 10'd600; SpriteY = 10'd400;
        cycle(1'b1, 0, 0);
        for (int xx = 590; xx < 640; xx++) cycle(1'b0, xx, 410);
        for (int xx = 0; xx < 24; xx++) cycle(1'b0, xx, 410);
        cycle(1'b0, 620, 410);
        cycle(1'b0, 620, 410);
        cycle(1'b0, 620, 410);
        chk("t6_hit_before_rst", sprite_on, 1);
        Reset_n = 1'b0;
        #1;
        chk("t6_rst_sprite_on", sprite_on, 0);
        chk("t6_rst_pal", pal_index, TRANSP);
        chk("t6_rst_addr", rom_addr, 0);
        chk("t6_rst_frame", anim_frame, 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
        for (int xx = 0; xx < 64; xx++) cycle(1'b0, xx, xx);
        chk("t6_no_pos_valid", sprite_on, 0);

        // Random traffic: positions change every clock but only latch on frame_start.
        for (int i = 0; i < 3000; i++) begin
            SpriteX = 10'($urandom_range(0, 700));
            SpriteY = 10'($urandom_range(0, 500));
            anim_en = 1'($urandom_range(0, 1));
            x = m_sx - 10 + int'($urandom_range(0, 90));
            y = m_sy - 10 + int'($urandom_range(0, 90));
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            cycle($urandom_range(0, 15) == 0, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
